// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with registered read data.
// Storage array and both pointers are exported for debug visibility.
// Overflowing writes and underflowing reads are silently dropped.
// Optional macro FIFO_STOR_CLEAR_EN: when defined, reset also zeroes every
// storage entry; otherwise storage keeps its contents across reset.
// Note: rst_n is synchronous and active-HIGH despite its name.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 12,
    localparam int PW   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read,
    input  logic             write,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] stor [SIZE],
    output logic [PW-1:0]    read_p,
    output logic [PW-1:0]    write_p
);

    localparam int CW = $clog2(SIZE + 1);

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          rd_ok;
    logic          wr_ok;

    // Pointers wrap at SIZE-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(SIZE));
    // A full FIFO still accepts a write when a read frees a slot in the same edge.
    assign rd_ok = read && !empty;
    assign wr_ok = write && (!full || read);

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            read_p    <= '0;
            write_p   <= '0;
            count     <= '0;
            read_data <= '0;
        end else begin
            if (rd_ok) begin
                read_data <= stor[read_p];
                read_p    <= next_ptr(read_p);
            end
            if (wr_ok) begin
                write_p <= next_ptr(write_p);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_STOR_CLEAR_EN
    // Storage writes; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                stor[i] <= '0;
            end
        end else if (wr_ok) begin
            stor[write_p] <= write_data;
        end
    end
`else
    // Storage writes; contents survive reset, only writes are blocked during it.
    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            stor[write_p] <= write_data;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table for the documented scenarios, then
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int SIZE  = 12;
    localparam int PW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] stor [SIZE];
    logic [PW-1:0]    read_p;
    logic [PW-1:0]    write_p;

    int nvec  = 0;
    int nfail = 0;

    sync_fifo #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read       (read),
        .write      (write),
        .write_data (write_data),
        .read_data  (read_data),
        .stor       (stor),
        .read_p     (read_p),
        .write_p    (write_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rd;
        logic       wr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        int         exp_rp;
        int         exp_wp;
        int         sidx;
        logic [7:0] sval;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic rd, input logic wr,
                                input logic [7:0] wd, input logic [7:0] exp_rd,
                                input int exp_rp, input int exp_wp,
                                input int sidx, input logic [7:0] sval,
                                input string name);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.wd = wd; v.exp_rd = exp_rd;
        v.exp_rp = exp_rp; v.exp_wp = exp_wp; v.sidx = sidx; v.sval = sval;
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state for the random phase.
    logic [7:0] mq[$];
    logic [7:0] mmem [SIZE];
    bit         mknown [SIZE];
    int         mrp;
    int         mwp;
    logic [7:0] mrd;

    initial begin
        rst_n = 1'b1; read = 1'b0; write = 1'b0; write_data = '0;

        // ---------------- directed table ----------------
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, -1, 8'h00, "reset");
        add(0, 1, 0, 8'h00, 8'h00, 0, 0, -1, 8'h00, "underflow");
        add(0, 1, 1, 8'h54, 8'h00, 0, 1,  0, 8'h54, "empty_rw");
        for (int k = 0; k < 20; k++) begin
            if (k < 11)
                add(0, 0, 1, 8'(8'h55 + k), 8'h00, 0, (k + 2) % SIZE, k + 1, 8'(8'h55 + k), "fill");
            else
                add(0, 0, 1, 8'(8'h55 + k), 8'h00, 0, 0, 0, 8'h54, "overflow_drop");
        end
        add(0, 1, 1, 8'h68, 8'h54, 1, 1, 0, 8'h68, "full_rw");
        for (int j = 0; j < 15; j++) begin
            if (j < 11)
                add(0, 1, 0, 8'h00, 8'(8'h55 + j), (j + 2) % SIZE, 1, -1, 8'h00, "drain");
            else
                add(0, 1, 0, 8'h00, 8'h68, 1, 1, -1, 8'h00, "drain_tail");
        end
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 1, 8'(8'hA0 + k), 8'h68, 1, k + 2, k + 1, 8'(8'hA0 + k), "refill");
        end
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, -1, 8'h00, "mid_reset");
        add(0, 1, 0, 8'h00, 8'h00, 0, 0, -1, 8'h00, "read_after_reset");

        foreach (vecs[i]) begin
            rst_n      = vecs[i].rst;
            read       = vecs[i].rd;
            write      = vecs[i].wr;
            write_data = vecs[i].wd;
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".read_data"}, 32'(read_data), 32'(vecs[i].exp_rd));
            chk({vecs[i].name, ".read_p"},    32'(read_p),    32'(vecs[i].exp_rp));
            chk({vecs[i].name, ".write_p"},   32'(write_p),   32'(vecs[i].exp_wp));
            if (vecs[i].sidx >= 0)
                chk({vecs[i].name, ".stor"}, 32'(stor[vecs[i].sidx]), 32'(vecs[i].sval));
`ifdef FIFO_STOR_CLEAR_EN
            if (vecs[i].rst) begin
                for (int s = 0; s < SIZE; s++) chk("reset.stor_clear", 32'(stor[s]), 32'h0);
            end
`endif
        end

        // ---------------- randomized traffic vs model ----------------
        mq.delete();
        mrp = 0; mwp = 0; mrd = 8'h00;
        for (int s = 0; s < SIZE; s++) begin mmem[s] = 8'h00; mknown[s] = 1'b0; end

        for (int c = 0; c < 600; c++) begin
            bit r, w, rs, do_r, do_w;
            logic [7:0] d;
            rs = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 99) < 45);
            w  = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 65 : 35));
            d  = 8'($urandom);
            rst_n = rs; read = r; write = w; write_data = d;

            if (rs) begin
                mq.delete();
                mrp = 0; mwp = 0; mrd = 8'h00;
`ifdef FIFO_STOR_CLEAR_EN
                for (int s = 0; s < SIZE; s++) begin mmem[s] = 8'h00; mknown[s] = 1'b1; end
`endif
            end else begin
                do_r = r && (mq.size() != 0);
                do_w = w && ((mq.size() != SIZE) || r);
                if (do_r) begin
                    mrd = mq.pop_front();
                    mrp = (mrp + 1) % SIZE;
                end
                if (do_w) begin
                    mq.push_back(d);
                    mmem[mwp]   = d;
                    mknown[mwp] = 1'b1;
                    mwp = (mwp + 1) % SIZE;
                end
            end

            @(posedge clk);
            #1;
            chk("rand.read_data", 32'(read_data), 32'(mrd));
            chk("rand.read_p",    32'(read_p),    32'(mrp));
            chk("rand.write_p",   32'(write_p),   32'(mwp));
            for (int s = 0; s < SIZE; s++) begin
                if (mknown[s]) chk("rand.stor", 32'(stor[s]), 32'(mmem[s]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised-depth circular-buffer FIFO with registered read data. It buffers WIDTH-bit words between a producer and consumer in the same clock domain. The full storage array and both pointers are exported for debug and scoreboard visibility. There are no full/empty ports; overflow and underflow are handled internally by dropping the offending request.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- SIZE, 12, depth in entries (≥2; need not be a power of two)
- PW, derived $clog2(SIZE), pointer width; not overridable

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge
- rst_n  input  1  reset; synchronous, active-high (asserted when 1, despite the name)
- read  input  1  read request, sampled each edge
- write  input  1  write request, sampled each edge
- write_data  input  WIDTH  data written on an accepted write
- read_data  output  WIDTH  registered data of the last accepted read
- stor  output  WIDTH × [SIZE]  unpacked storage array, entry i = stor[i]
- read_p  output  PW  index of the oldest entry
- write_p  output  PW  index of the next free slot

## Operation
- Internal occupancy counter count: 0..SIZE, $clog2(SIZE+1) bits. Empty is count==0; full is count==SIZE.
- Write accepted when write && (!full || read). On acceptance, stor[write_p] <= write_data and write_p advances.
- Read accepted when read && !empty. On acceptance, read_data <= stor[read_p] and read_p advances.
- Pointer advance: SIZE-1 wraps to 0; otherwise +1. Values ≥ SIZE are never reached.
- Count: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous read+write:
  - When empty: write accepted, read ignored. No bypass; read_data holds.
  - When full: both accepted. The read returns the old stor[read_p]; the write lands in the slot that was just freed, since write_p==read_p.
  - Otherwise: both accepted.
- Write to full without read is dropped; stor, write_p and count are unchanged.
- Read of empty is dropped; read_data, read_p and count are unchanged.
- read_data holds its value between accepted reads.
- Reset, when rst_n==1 at a posedge, overrides read/write:
  - read_p=0, write_p=0, count=0, read_data=0.
  - stor is handled according to Configuration.
  - Reset mid-operation discards all contents.

## Timing
- Fully synchronous, no combinational input→output paths.
- Read latency: read_data valid one edge after read is sampled.
- Write visibility: stor and write_p update at the accepting edge, so a written word is readable from the next cycle.
- Reset takes effect at the first posedge with rst_n==1. Normal operation resumes at the first edge with rst_n==0.

## Configuration
- FIFO_STOR_CLEAR_EN defined: reset also clears every stor entry to 0.
- Not defined: stor is not reset. It retains prior contents, or X after power-up; only pointers, count and read_data are reset.

## Test plan
- Reset: assert rst_n=1 for one edge → read_p=0, write_p=0, read_data=0, and stor all 0 with FIFO_STOR_CLEAR_EN.
- Underflow and empty read+write: after reset, read=1 for one cycle → read_p stays 0 and read_data stays 0. Then read=1, write=1, write_data=0x54 → stor[0]=0x54, write_p=1, read_p=0.
- Fill, wrap and overflow: from count 1, write 0x55..0x68 one per cycle, read=0 → 0x55..0x5F land in stor[1..11] and write_p wraps to 0. Writes 0x60..0x68 are dropped and stor[0] stays 0x54.
- Full simultaneous read+write: full with write_data=0x68 and read=write=1 → read_data=0x54, stor[0]=0x68, read_p=1, write_p=1.
- Drain: read=1, write=0 for 15 cycles → read_data sequence 0x55..0x5F, then 0x68. read_p wraps 11→0 and stops at 1; afterwards read_data holds 0x68 and read_p stays 1.
- Mid-operation reset: with count=5, assert rst_n for one edge → pointers 0 and read_data=0. A subsequent read with no prior write is ignored.
